// File: rtl/bitcnt_arbiter.sv
// Two-requester round-robin front end sharing a single bit-count unit.
// Ops (func[2:1]): 00 clz, 01 ctz, 10 popcount, 11 illegal; func[0] selects 32-bit mode.

module bitcnt (
   input  logic [63:0] din_data,
   input  logic [2:0]  din_func,
   input  logic        mutsel,
   output logic [63:0] dout_data
);

   logic [63:0] opnd;
   logic [63:0] clz_v;
   logic [63:0] ctz_v;
   logic [6:0]  clz_cnt;
   logic [6:0]  ctz_cnt;
   logic [6:0]  pop_cnt;
   logic        clz_done;
   logic        ctz_done;

   // mutsel inverts the operand so the same counters count zeros instead of ones
   always_comb begin
      opnd = mutsel ? ~din_data : din_data;
      if (din_func[0]) opnd[63:32] = '0;
      // 32-bit mode pads with ones so clz/ctz of a zero word stops at 32
      clz_v    = din_func[0] ? {opnd[31:0], 32'hFFFF_FFFF} : opnd;
      ctz_v    = din_func[0] ? {32'hFFFF_FFFF, opnd[31:0]} : opnd;
      clz_cnt  = '0;
      ctz_cnt  = '0;
      pop_cnt  = '0;
      clz_done = 1'b0;
      ctz_done = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (!clz_done) begin
            if (clz_v[63-i]) clz_done = 1'b1;
            else             clz_cnt  = clz_cnt + 7'd1;
         end
         if (!ctz_done) begin
            if (ctz_v[i]) ctz_done = 1'b1;
            else          ctz_cnt  = ctz_cnt + 7'd1;
         end
         pop_cnt = pop_cnt + 7'(opnd[i]);
      end
      case (din_func[2:1])
         2'b00:   dout_data = 64'(clz_cnt);
         2'b01:   dout_data = 64'(ctz_cnt);
         2'b10:   dout_data = 64'(pop_cnt);
         default: dout_data = '0;
      endcase
   end

endmodule

module bitcnt_arbiter #(
   parameter logic RR_INIT = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_data,
   input  logic [2:0]  req0_func,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_data,
   input  logic [2:0]  req1_func,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic        resp_id,
   output logic        resp_err
);

   localparam int unsigned DW = 64;
   localparam int unsigned FW = 3;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          rr_last;
   logic [DW-1:0] op_data;
   logic [FW-1:0] op_func;
   logic          op_id;
   logic          gnt_any;
   logic          gnt_id;
   logic [DW-1:0] unit_din;
   logic [DW-1:0] unit_dout;
   logic          op_illegal;

   // Round-robin pick: a lone requester wins, a tie goes away from the last grant
   always_comb begin
      gnt_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) gnt_id = ~rr_last;
      else                          gnt_id = req1_valid;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_any) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is gated by resetn so a held request is never acknowledged during reset
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      resp_valid = 1'b0;
      if (state == IDLE && resetn) begin
         req0_ready = gnt_any & ~gnt_id;
         req1_ready = gnt_any &  gnt_id;
      end
      if (state == RESP) resp_valid = 1'b1;
   end

   assign op_illegal = (op_func[2:1] == 2'b11);
   assign unit_din   = op_func[0] ? {32'h0, op_data[31:0]} : op_data;

   bitcnt u_bitcnt (
      .din_data  (unit_din),
      .din_func  (op_func),
      .mutsel    (1'b0),
      .dout_data (unit_dout)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_last   <= RR_INIT;
         op_data   <= '0;
         op_func   <= '0;
         op_id     <= 1'b0;
         resp_data <= '0;
         resp_id   <= 1'b0;
         resp_err  <= 1'b0;
      end else begin
         if (state == IDLE && gnt_any) begin
            rr_last <= gnt_id;
            op_id   <= gnt_id;
            op_data <= gnt_id ? req1_data : req0_data;
            op_func <= gnt_id ? req1_func : req0_func;
         end
         if (state == EXEC) begin
            resp_id  <= op_id;
            resp_err <= op_illegal;
            if (op_illegal)      resp_data <= '0;
            else if (op_func[0]) resp_data <= {32'h0, unit_dout[31:0]};
            else                 resp_data <= unit_dout;
         end
      end
   end

endmodule

// File: tb/tb_bitcnt_arbiter.sv
// Directed bench for bitcnt_arbiter: op results, latency, round-robin order, backpressure, reset.

module tb_bitcnt_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [63:0] req0_data, req1_data;
   logic [2:0]  req0_func, req1_func;
   logic        resp_valid, resp_ready;
   logic [63:0] resp_data;
   logic        resp_id, resp_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bitcnt_arbiter #(.RR_INIT(1'b1)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req0_func  (req0_func),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .req1_func  (req1_func),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_err   (resp_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   // One request from requester id, full-throughput consumer, checks every cycle of the flow
   task automatic single(input string tag, input bit id, input logic [63:0] d,
                         input logic [2:0] f, input logic [63:0] exp_data, input bit exp_err);
      @(posedge clk); #1;
      resp_ready = 1'b1;
      if (id) begin req1_valid = 1'b1; req1_data = d; req1_func = f; end
      else    begin req0_valid = 1'b1; req0_data = d; req0_func = f; end
      @(negedge clk);
      chk({tag, "_rdy"}, 64'({req1_ready, req0_ready}), id ? 64'd2 : 64'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_exec_v"}, 64'(resp_valid), 64'd0);
      @(negedge clk);
      chk({tag, "_v"},    64'(resp_valid), 64'd1);
      chk({tag, "_data"}, resp_data, exp_data);
      chk({tag, "_id"},   64'(resp_id), 64'(id));
      chk({tag, "_err"},  64'(resp_err), 64'(exp_err));
      @(negedge clk);
      chk({tag, "_done_v"}, 64'(resp_valid), 64'd0);
   endtask

   initial begin
      bit exp_id;
      bit q[$];
      bit eid;
      int gcnt;
      int last_hs;

      resetn = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 64'h5; req1_data = 64'h6;
      req0_func = 3'b000; req1_func = 3'b000;
      resp_ready = 1'b0;
      #3;
      chk("rst_rdy",   64'({req1_ready, req0_ready}), 64'd0);
      chk("rst_valid", 64'(resp_valid), 64'd0);
      chk("rst_data",  resp_data, 64'd0);
      chk("rst_id",    64'(resp_id), 64'd0);
      chk("rst_err",   64'(resp_err), 64'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      do_reset();

      single("illegal0", 1'b0, 64'h1234_5678_9ABC_DEF0, 3'b110, 64'h0, 1'b1);
      single("clz_one",  1'b0, 64'h0000_0000_0000_0001, 3'b000, 64'd63, 1'b0);
      single("clz_msb",  1'b1, 64'h8000_0000_0000_0000, 3'b000, 64'd0,  1'b0);
      single("clz_zero", 1'b0, 64'h0,                   3'b000, 64'd64, 1'b0);
      single("ctz_8",    1'b1, 64'h0000_0000_0000_0100, 3'b010, 64'd8,  1'b0);
      single("ctz_zero", 1'b0, 64'h0,                   3'b010, 64'd64, 1'b0);
      single("pop_20",   1'b0, 64'hFFFF_0000_0000_000F, 3'b100, 64'd20, 1'b0);
      single("pop_all",  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 64'd64, 1'b0);
      single("clzw_1",   1'b0, 64'hFFFF_FFFF_0000_0001, 3'b001, 64'd31, 1'b0);
      single("ctzw_hi",  1'b1, 64'hFFFF_FFFF_0000_0000, 3'b011, 64'd32, 1'b0);
      single("ctzw_0",   1'b1, 64'h0,                   3'b011, 64'd32, 1'b0);
      single("popw_8",   1'b1, 64'hFFFF_FFFF_0000_00FF, 3'b101, 64'd8,  1'b0);
      single("illegal1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 64'h0, 1'b1);

      // Both requesters held: first grant right after reset, then strict alternation
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_data = 64'h1; req0_func = 3'b000;
      req1_valid = 1'b1; req1_data = 64'hF; req1_func = 3'b100;
      resp_ready = 1'b1;
      resetn = 1'b1;
      exp_id = 1'b0;
      gcnt = 0;
      last_hs = -10;
      for (int cyc = 0; cyc < 200 && gcnt < 10; cyc++) begin
         @(negedge clk);
         if (resp_valid && resp_ready) begin
            chk("fair_q", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
               eid = q.pop_front();
               chk("fair_rid",   64'(resp_id), 64'(eid));
               chk("fair_rdata", resp_data, eid ? 64'd4 : 64'd63);
            end
            last_hs = cyc;
         end
         if (req0_ready || req1_ready) begin
            chk("fair_onehot", 64'(req0_ready & req1_ready), 64'd0);
            chk("fair_order",  64'(req1_ready), 64'(exp_id));
            if (gcnt > 0) chk("fair_gap", 64'(cyc - last_hs), 64'd1);
            else          chk("first_gnt", 64'(cyc), 64'd0);
            q.push_back(req1_ready);
            exp_id = ~exp_id;
            gcnt++;
         end
      end
      chk("fair_count", 64'(gcnt), 64'd10);
      req0_valid = 1'b0; req1_valid = 1'b0;
      do_reset();
      q.delete();

      // Backpressure with both requests still pending
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req0_valid = 1'b1; req0_data = 64'h0000_0000_0000_00F0; req0_func = 3'b010;
      req1_valid = 1'b1; req1_data = 64'h3; req1_func = 3'b100;
      @(negedge clk);
      chk("bp_gnt", 64'({req1_ready, req0_ready}), 64'd1);
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 64'(resp_valid), 64'd1);
         chk("bp_data",  resp_data, 64'd4);
         chk("bp_id",    64'(resp_id), 64'd0);
         chk("bp_err",   64'(resp_err), 64'd0);
         chk("bp_rdy",   64'({req1_ready, req0_ready}), 64'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release", 64'(resp_valid), 64'd0);

      // Reset while a request sits in EXEC, with stale nonzero response registers
      single("pre_rst", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 64'd64, 1'b0);
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_data = 64'h1; req0_func = 3'b000;
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      chk("rx_valid", 64'(resp_valid), 64'd0);
      chk("rx_data",  resp_data, 64'd0);
      chk("rx_id",    64'(resp_id), 64'd0);
      chk("rx_err",   64'(resp_err), 64'd0);
      chk("rx_rdy",   64'({req1_ready, req0_ready}), 64'd0);
      req0_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rx_quiet", 64'(resp_valid), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
